// File: rtl/w_pulse_tx_pkg.sv
// Shared definitions for the w pulse transmitter and the downstream mod-5 w counter.
// Holds the 2-bit state encoding and the counter modulus.
package w_pulse_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned W_MOD = 5;

endpackage

// File: rtl/w_pulse_tx_gap_timer.sv
// Inter-pulse gap timer: loadable down-counter with a terminal-count expire flag.
// Loaded with (gap - 1) so expire marks the final gap cycle.
module gap_timer #(
    parameter int GAP_W = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_val,
    output logic             expire
);

    logic [GAP_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - GAP_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/w_pulse_tx.sv
// Burst transmitter for the w pulse stream feeding the mod-5 w counter; tallies the
// counter's Mealy flag during pulses and checks it against the expected count.
//   state | meaning
//   IDLE  | waiting for start; tallies from the last burst held
//   HIGH  | w=1 for one cycle, one pulse emitted
//   GAP   | w=0 for gap_len cycles between pulses
//   DONE  | one-cycle done strobe, match valid
module w_pulse_tx
    import w_pulse_tx_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             count_in,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] pulses_sent,
    output logic [CNT_W-1:0] count_seen
);

    localparam logic [CNT_W:0] MOD_V = (CNT_W+1)'(W_MOD);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic [GAP_W-1:0] gap_lat;
    logic             last_pulse;
    logic             gap_expire;
    logic             accept;
    logic [CNT_W:0]   num_p1;
    logic [CNT_W:0]   count_exp;

    assign accept     = (state == IDLE) && start;
    assign last_pulse = (pulses_sent == (num_lat - CNT_W'(1)));

    gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clock   (clock),
        .rst     (rst),
        .load    (state == HIGH),
        .load_val(gap_lat - GAP_W'(1)),
        .expire  (gap_expire)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_pulses == '0) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_pulse) begin
                    state_nxt = DONE;
                end else if (gap_lat == '0) begin
                    state_nxt = HIGH;
                end else begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (gap_expire) begin
                    state_nxt = HIGH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            num_lat     <= '0;
            gap_lat     <= '0;
            pulses_sent <= '0;
            count_seen  <= '0;
        end else if (accept) begin
            num_lat     <= num_pulses;
            gap_lat     <= gap_len;
            pulses_sent <= '0;
            count_seen  <= '0;
        end else if (state == HIGH) begin
            pulses_sent <= pulses_sent + CNT_W'(1);
            if (count_in && (count_seen != '1)) begin
                count_seen <= count_seen + CNT_W'(1);
            end
        end
    end

    // Downstream counter starts in state 0, so its first flag lands on pulse MOD-1.
    assign num_p1    = {1'b0, num_lat} + (CNT_W+1)'(1);
    assign count_exp = num_p1 / MOD_V;

    assign w     = (state == HIGH);
    assign busy  = (state == HIGH) || (state == GAP);
    assign done  = (state == DONE);
    assign match = (state == DONE) && ({1'b0, count_seen} == count_exp);

endmodule
